// File: rtl/md5_sched_pkg.sv
// Shared types and helpers for the MD5 core dispatch scheduler.
package md5_sched_pkg;

    localparam int DIGEST_W = 128;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_FOUND
    } state_t;

    // Index width for n cores; a single core still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick_first.sv
// Rotating priority encoder: first requester at or after ptr, wrapping around.
module rr_pick_first #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          hit
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!hit && req[j]) begin
                hit      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/md5_dispatch_sched.sv
// Round-robin dispatch of candidate messages to shared MD5 cores with digest match tracking.
//   state    | meaning
//   ST_IDLE  | after reset, waiting for start
//   ST_RUN   | accepting candidates and issuing to free cores
//   ST_DRAIN | last candidate issued, waiting for in-flight digests
//   ST_DONE  | keyspace exhausted without a match
//   ST_FOUND | match latched, results held until next start
module md5_dispatch_sched
    import md5_sched_pkg::*;
#(
    parameter int NUM_CORES    = 2,
    parameter int MSG_W        = 128,
    parameter int MSG_LEN_BITS = 64,
    parameter int CNT_W        = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DIGEST_W-1:0]           target,
    input  logic [MSG_W-1:0]              cand_data,
    input  logic                          cand_valid,
    input  logic                          cand_last,
    output logic                          cand_ready,
    output logic [NUM_CORES*MSG_W-1:0]    core_msg,
    output logic [NUM_CORES*8-1:0]        core_width,
    output logic [NUM_CORES-1:0]          core_valid,
    input  logic [NUM_CORES-1:0]          core_ready,
    input  logic [NUM_CORES*DIGEST_W-1:0] core_digest,
    input  logic [NUM_CORES-1:0]          core_digest_valid,
    output logic                          found,
    output logic                          exhausted,
    output logic [MSG_W-1:0]              found_msg,
    output logic [2:0]                    found_core,
    output logic                          busy,
    output logic [CNT_W-1:0]              issued_cnt
);

    localparam int IW = idx_w(NUM_CORES);

    state_t                state, state_nx;
    logic [IW-1:0]         rr_ptr, pick_idx, match_idx;
    logic [NUM_CORES-1:0]  inflight, eligible, pick_grant, done_v;
    logic                  pick_hit, accept, match_any, match_ev, run_or_drain, restart;
    logic [DIGEST_W-1:0]   target_q;
    logic [MSG_W-1:0]      tag [NUM_CORES];

    assign eligible     = core_ready & ~inflight;
    assign run_or_drain = (state == ST_RUN) || (state == ST_DRAIN);
    assign busy         = run_or_drain;
    assign cand_ready   = (state == ST_RUN) && pick_hit;
    assign accept       = cand_valid && cand_ready;
    assign done_v       = core_digest_valid & inflight;
    assign restart      = start && !run_or_drain;
    assign core_width   = {NUM_CORES{8'(MSG_LEN_BITS)}};

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_msg
        assign core_msg[g*MSG_W +: MSG_W] = tag[g];
    end

    rr_pick_first #(.N(NUM_CORES), .IW(IW)) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .hit   (pick_hit)
    );

    // Descending scan so the lowest-index matching core wins.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (done_v[i] && (core_digest[i*DIGEST_W +: DIGEST_W] == target_q)) begin
                match_any = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    assign match_ev = match_any && run_or_drain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN: begin
                if (match_ev)                state_nx = ST_FOUND;
                else if (accept && cand_last) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (match_ev)              state_nx = ST_FOUND;
                else if (inflight == '0)   state_nx = ST_DONE;
            end
            ST_DONE, ST_FOUND: if (start) state_nx = ST_RUN;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            inflight   <= '0;
            core_valid <= '0;
            target_q   <= '0;
            issued_cnt <= '0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            found_msg  <= '0;
            found_core <= '0;
            for (int i = 0; i < NUM_CORES; i++) tag[i] <= '0;
        end else begin
            core_valid <= accept ? pick_grant : '0;
            inflight   <= (inflight & ~done_v) | (accept ? pick_grant : '0);
            if (accept) begin
                tag[pick_idx] <= cand_data;
                rr_ptr        <= (pick_idx == IW'(NUM_CORES - 1)) ? '0 : pick_idx + IW'(1);
                if (issued_cnt != '1) issued_cnt <= issued_cnt + CNT_W'(1);
            end
            // In-flight cores are left alone on restart; their late digests meet the new target.
            if (restart) begin
                target_q   <= target;
                found      <= 1'b0;
                exhausted  <= 1'b0;
                issued_cnt <= '0;
                found_msg  <= '0;
                found_core <= '0;
            end
            if (match_ev) begin
                found      <= 1'b1;
                found_msg  <= tag[match_idx];
                found_core <= 3'(match_idx);
            end
            if (state == ST_DRAIN && !match_ev && inflight == '0) exhausted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_md5_dispatch_sched.sv
// Directed bench for md5_dispatch_sched with behavioural MD5 cores (digest = msg ^ 5A.., fixed latency).
module tb_md5_dispatch_sched;

    localparam int NC = 2;
    localparam logic [127:0] MASK = {16{8'h5A}};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [127:0]      target = '0;
    logic [127:0]      cand_data = '0;
    logic              cand_valid = 1'b0;
    logic              cand_last = 1'b0;
    logic              cand_ready;
    logic [NC*128-1:0] core_msg;
    logic [NC*8-1:0]   core_width;
    logic [NC-1:0]     core_valid;
    logic [NC-1:0]     core_ready;
    logic [NC*128-1:0] core_digest;
    logic [NC-1:0]     core_digest_valid;
    logic              found, exhausted, busy;
    logic [127:0]      found_msg;
    logic [2:0]        found_core;
    logic [31:0]       issued_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    md5_dispatch_sched #(.NUM_CORES(NC), .MSG_W(128), .MSG_LEN_BITS(64), .CNT_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .target            (target),
        .cand_data         (cand_data),
        .cand_valid        (cand_valid),
        .cand_last         (cand_last),
        .cand_ready        (cand_ready),
        .core_msg          (core_msg),
        .core_width        (core_width),
        .core_valid        (core_valid),
        .core_ready        (core_ready),
        .core_digest       (core_digest),
        .core_digest_valid (core_digest_valid),
        .found             (found),
        .exhausted         (exhausted),
        .found_msg         (found_msg),
        .found_core        (found_core),
        .busy              (busy),
        .issued_cnt        (issued_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural cores plus an injection path for spurious digests.
    logic [NC-1:0] m_rdy, m_dv, m_busy;
    logic [127:0]  m_msg [NC];
    logic [127:0]  m_dig [NC];
    int            m_cnt [NC];
    int            lat [NC] = '{20, 20};
    logic [NC-1:0] spur_dv = '0;
    logic [127:0]  spur_dig = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NC; i++) begin
                m_rdy[i] <= 1'b1; m_dv[i] <= 1'b0; m_busy[i] <= 1'b0;
                m_cnt[i] <= 0; m_msg[i] <= '0; m_dig[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                m_dv[i] <= 1'b0;
                if (core_valid[i]) begin
                    m_busy[i] <= 1'b1; m_rdy[i] <= 1'b0;
                    m_cnt[i] <= lat[i]; m_msg[i] <= core_msg[i*128 +: 128];
                end else if (m_busy[i]) begin
                    if (m_cnt[i] == 1) begin
                        m_dv[i] <= 1'b1; m_dig[i] <= m_msg[i] ^ MASK;
                        m_busy[i] <= 1'b0; m_rdy[i] <= 1'b1;
                    end else begin
                        m_cnt[i] <= m_cnt[i] - 1;
                    end
                end
            end
        end
    end

    assign core_ready        = m_rdy;
    assign core_digest_valid = m_dv | spur_dv;
    always_comb begin
        core_digest = '0;
        for (int i = 0; i < NC; i++) core_digest[i*128 +: 128] = spur_dv[i] ? spur_dig : m_dig[i];
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cand_valid = 1'b0; cand_last = 1'b0; start = 1'b0; spur_dv = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic [127:0] t);
        @(negedge clk);
        target = t; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one candidate; returns right after the accepting edge (or at budget expiry).
    task automatic send(input logic [127:0] d, input logic last, input int budget,
                        output bit ok, output logic [NC-1:0] got, output int at);
        ok = 1'b0; got = '0; at = 0;
        @(negedge clk);
        cand_data = d; cand_valid = 1'b1; cand_last = last;
        for (int k = 0; k < budget; k++) begin
            if (cand_ready) begin
                @(posedge clk); #1;
                ok = 1'b1; got = core_valid; at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        cand_valid = 1'b0; cand_last = 1'b0;
    endtask

    task automatic test_reset();
        logic [NC*8-1:0] w_exp;
        w_exp = {NC{8'd64}};
        do_reset();
        checks++;
        if ({found, exhausted, busy, cand_ready} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags got=%b exp=0000", {found, exhausted, busy, cand_ready});
        end
        checks++;
        if (issued_cnt !== 32'd0 || core_valid !== '0) begin
            failures++; $display("FAIL reset_cnt issued=%0d core_valid=%b exp 0/0", issued_cnt, core_valid);
        end
        checks++;
        if (found_msg !== '0 || found_core !== 3'd0) begin
            failures++; $display("FAIL reset_found msg=%h core=%0d exp 0/0", found_msg, found_core);
        end
        checks++;
        if (core_width !== w_exp) begin
            failures++; $display("FAIL reset_width got=%h exp=%h", core_width, w_exp);
        end
    endtask

    task automatic test_match();
        logic [127:0] c [8];
        bit ok; logic [NC-1:0] got; int at; int n_ok;
        n_ok = 0;
        for (int k = 0; k < 8; k++) c[k] = 128'h61616161 + 128'(k + 1);
        do_reset();
        pulse_start(c[4] ^ MASK);
        for (int k = 0; k < 8; k++) begin
            send(c[k], k == 7, 60, ok, got, at);
            if (ok) n_ok++;
        end
        idle();
        checks++;
        if (found !== 1'b1 || exhausted !== 1'b0) begin
            failures++; $display("FAIL match_flags found=%b exhausted=%b exp 1/0", found, exhausted);
        end
        checks++;
        if (found_msg !== c[4] || found_core !== 3'd0) begin
            failures++; $display("FAIL match_result msg=%h core=%0d exp %h/0", found_msg, found_core, c[4]);
        end
        checks++;
        if (issued_cnt !== 32'd6 || n_ok != 6) begin
            failures++; $display("FAIL match_issued cnt=%0d accepted=%0d exp 6/6", issued_cnt, n_ok);
        end
    endtask

    task automatic test_back_to_back();
        logic [NC-1:0] got [4];
        int at [4];
        bit ok;
        do_reset();
        pulse_start(128'h0);
        for (int k = 0; k < 4; k++) send(128'h1000 + 128'(k), 1'b0, 60, ok, got[k], at[k]);
        idle();
        checks++;
        if (got[0] !== 2'b01 || got[1] !== 2'b10 || got[2] !== 2'b01 || got[3] !== 2'b10) begin
            failures++;
            $display("FAIL b2b_grants got=%b,%b,%b,%b exp=01,10,01,10", got[0], got[1], got[2], got[3]);
        end
        checks++;
        if (at[1] - at[0] != 1) begin
            failures++; $display("FAIL b2b_second_gap got=%0d exp=1", at[1] - at[0]);
        end
        checks++;
        if (at[2] - at[0] != 23) begin
            failures++; $display("FAIL b2b_third_waits got=%0d exp=23", at[2] - at[0]);
        end
    endtask

    task automatic test_exhaust();
        bit ok; logic [NC-1:0] got; int at; int n_ok; bit seen;
        n_ok = 0; seen = 1'b0;
        do_reset();
        pulse_start(128'h0);
        for (int k = 0; k < 6; k++) begin
            send(128'h2000 + 128'(k), k == 5, 60, ok, got, at);
            if (ok) n_ok++;
        end
        checks++;
        if (cand_ready !== 1'b0 || busy !== 1'b1 || n_ok != 6) begin
            failures++; $display("FAIL exh_drain ready=%b busy=%b accepted=%0d exp 0/1/6", cand_ready, busy, n_ok);
        end
        idle();
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (exhausted === 1'b1) seen = 1'b1;
        end
        checks++;
        if (exhausted !== 1'b1 || found !== 1'b0) begin
            failures++; $display("FAIL exh_flags exhausted=%b found=%b exp 1/0", exhausted, found);
        end
        checks++;
        if (issued_cnt !== 32'd6 || busy !== 1'b0 || cand_ready !== 1'b0) begin
            failures++; $display("FAIL exh_final cnt=%0d busy=%b ready=%b exp 6/0/0", issued_cnt, busy, cand_ready);
        end
    endtask

    task automatic test_simul_match();
        logic [127:0] x;
        bit ok; logic [NC-1:0] got; int at; bit both; bit extra;
        both = 1'b0; extra = 1'b0;
        x = 128'hDEADBEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
        do_reset();
        lat[0] = 21; lat[1] = 20;
        pulse_start(x ^ MASK);
        send(x, 1'b0, 60, ok, got, at);
        send(x, 1'b0, 60, ok, got, at);
        @(negedge clk);
        cand_data = 128'h7777;
        for (int k = 0; k < 60 && found !== 1'b1; k++) begin
            if (core_digest_valid === 2'b11) both = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (found !== 1'b1 || found_core !== 3'd0 || found_msg !== x || !both) begin
            failures++;
            $display("FAIL simul_lowest found=%b core=%0d msg=%h both=%b exp 1/0/%h/1", found, found_core, found_msg, both, x);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (core_valid !== '0 || cand_ready !== 1'b0) extra = 1'b1;
        end
        checks++;
        if (extra || issued_cnt !== 32'd2) begin
            failures++; $display("FAIL simul_hold issue_seen=%b cnt=%0d exp 0/2", extra, issued_cnt);
        end
        idle();
        lat[0] = 20; lat[1] = 20;
    endtask

    task automatic test_reset_mid();
        logic [127:0] x;
        bit ok; logic [NC-1:0] got; int at;
        x = 128'hA5A5_0000_1111_2222;
        do_reset();
        pulse_start(x ^ MASK);
        send(128'h3000, 1'b0, 60, ok, got, at);
        send(128'h3001, 1'b0, 60, ok, got, at);
        @(negedge clk);
        reset = 1'b1; cand_valid = 1'b0;
        #1;
        checks++;
        if ({found, exhausted, busy, cand_ready} !== 4'b0000 || issued_cnt !== 32'd0 || core_valid !== '0) begin
            failures++;
            $display("FAIL midreset_clear flags=%b cnt=%0d cv=%b exp 0000/0/0", {found, exhausted, busy, cand_ready}, issued_cnt, core_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        pulse_start(x ^ MASK);
        send(x, 1'b0, 60, ok, got, at);
        idle();
        for (int k = 0; k < 60 && found !== 1'b1; k++) @(negedge clk);
        checks++;
        if (found !== 1'b1 || found_msg !== x || found_core !== 3'd0 || issued_cnt !== 32'd1) begin
            failures++;
            $display("FAIL midreset_replay found=%b msg=%h core=%0d cnt=%0d exp 1/%h/0/1", found, found_msg, found_core, issued_cnt, x);
        end
    endtask

    task automatic test_spurious();
        logic [127:0] x, t;
        bit ok; logic [NC-1:0] got; int at;
        x = 128'h0BAD_F00D;
        t = x ^ MASK;
        do_reset();
        pulse_start(t);
        @(negedge clk);
        spur_dig = t; spur_dv = 2'b10;
        @(negedge clk);
        spur_dv = 2'b01;
        @(negedge clk);
        spur_dv = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (found !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL spurious_ignored found=%b busy=%b exp 0/1", found, busy);
        end
        // start while running must not re-sample the target
        pulse_start(128'h0);
        send(x, 1'b0, 60, ok, got, at);
        idle();
        for (int k = 0; k < 60 && found !== 1'b1; k++) @(negedge clk);
        checks++;
        if (found !== 1'b1 || found_msg !== x || found_core !== 3'd0) begin
            failures++; $display("FAIL spurious_then_real found=%b msg=%h core=%0d exp 1/%h/0", found, found_msg, found_core, x);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_match();
        test_back_to_back();
        test_exhaust();
        test_simul_match();
        test_reset_mid();
        test_spurious();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
